// File: rtl/op_trans_pkg.sv
// Shared definitions for the op_trans attention path stages:
// slice geometry helpers and the merge FSM state encoding.
package op_trans_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } merge_state_t;

  function automatic int calc_slice_num(
    input int head_num,
    input int heads_per_slice
  );
    return head_num / heads_per_slice;
  endfunction

  function automatic int calc_slice_w(
    input int data_width,
    input int seq_len,
    input int heads_per_slice,
    input int head_dim
  );
    return data_width * seq_len * heads_per_slice * head_dim;
  endfunction

endpackage

// File: rtl/head_concat_merge.sv
// Reassembles head-group slices from the split stage into one full
// matrix and hands it downstream over an active-low valid/ready pair.
module head_concat_merge
  import op_trans_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int SEQ_LEN         = 128,
  parameter int HEADS_PER_SLICE = 4,
  parameter int HEAD_DIM        = 64,
  parameter int HEAD_NUM        = 12,
  localparam int SLICE_NUM =
    calc_slice_num(HEAD_NUM, HEADS_PER_SLICE),
  localparam int SLICE_W =
    calc_slice_w(DATA_WIDTH, SEQ_LEN, HEADS_PER_SLICE, HEAD_DIM),
  localparam int CNT_W =
    (SLICE_NUM > 1) ? $clog2(SLICE_NUM) : 1
) (
  input  logic                         clk_p,
  input  logic                         rst_p,
  input  logic [SLICE_W-1:0]           slice,
  input  logic                         slice_valid_n,
  output logic                         slice_ready_n,
  output logic [SLICE_NUM*SLICE_W-1:0] merged_matrix,
  output logic                         output_valid_n,
  input  logic                         out_ready_n
);

  if (HEAD_NUM % HEADS_PER_SLICE != 0) begin : g_bad_cfg
    $error("HEAD_NUM must be a multiple of HEADS_PER_SLICE");
  end

  merge_state_t     state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] slot;
  logic             valid_n_nx;
  logic             accept;

  // Ready depends on state only, so there is no input-to-output path.
  assign slice_ready_n = (state == DONE);
  assign accept = !slice_valid_n && !slice_ready_n;
  assign slot = (state == IDLE) ? '0 : count;

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    valid_n_nx = output_valid_n;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (SLICE_NUM == 1) begin
            state_nx   = DONE;
            count_nx   = '0;
            valid_n_nx = 1'b0;
          end else begin
            state_nx = COLLECT;
            count_nx = CNT_W'(1);
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count == CNT_W'(SLICE_NUM - 1)) begin
            state_nx   = DONE;
            count_nx   = '0;
            valid_n_nx = 1'b0;
          end else begin
            count_nx = count + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!out_ready_n) begin
          state_nx   = IDLE;
          valid_n_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state          <= IDLE;
      count          <= '0;
      output_valid_n <= 1'b1;
    end else begin
      state          <= state_nx;
      count          <= count_nx;
      output_valid_n <= valid_n_nx;
    end
  end

  // Only the addressed field changes; other slots keep their contents.
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      merged_matrix <= '0;
    end else if (accept) begin
      for (int k = 0; k < SLICE_NUM; k++) begin
        if (slot == CNT_W'(k)) begin
          merged_matrix[k*SLICE_W +: SLICE_W] <= slice;
        end
      end
    end
  end

endmodule
